serial_frame_deser: RTL and testbench

//  Consumes the LSB-first serial bit stream from the free-running shift-register stage.

---
 rtl/serdes_pkg.sv | 18 +
 rtl/shift_reg_en.sv | 37 +++
 rtl/serial_frame_deser.sv | 151 +++++++++++++++
 tb/tb_serial_frame_deser.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serial deserialiser: FSM state encoding and parity helper.
package serdes_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  // Widest word the parity helper folds; callers zero-extend into this width.
  localparam int unsigned PAR_MAX_W = 64;

  // Even parity of a word: 1 when the word holds an odd number of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// Right-shift register: new bit enters at the MSB, sync clear has priority over shift.
module shift_reg_en #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next value: clear, shift in at the top, or hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = {d_i, q_q[N-1:1]};
    end
  end

  // Storage with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserialiser: hunts for an LSB-first sync word, collects a data word
// plus even parity, and presents good words on a valid/ready port.
module serial_frame_deser
  import serdes_pkg::*;
#(
  parameter int unsigned    DW   = 8,
  parameter int unsigned    SW   = 8,
  parameter logic [SW-1:0]  SYNC = SW'(8'hA5)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_en,
  input  logic          s_in,
  input  logic          rx_ready,
  input  logic          clr_ovr,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          par_err,
  output logic          overrun,
  output logic          locked
);

  localparam int unsigned   CW       = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          par_err_q, par_err_d;
  logic          overrun_q, overrun_d;
  logic          locked_q, locked_d;

  logic [SW-1:0] win_q;
  logic [SW-1:0] win_cand;
  logic          win_en, win_clr;
  logic [DW-1:0] sh_q;
  logic          sh_en;

  // Sync window: only shifts while hunting, cleared after every parity bit.
  shift_reg_en #(.N(SW)) u_win (
    .clk   (clk),
    .reset (reset),
    .en_i  (win_en),
    .clr_i (win_clr),
    .d_i   (s_in),
    .q_o   (win_q)
  );

  // Data shifter: collects the word while locked.
  shift_reg_en #(.N(DW)) u_shift (
    .clk   (clk),
    .reset (reset),
    .en_i  (sh_en),
    .clr_i (1'b0),
    .d_i   (s_in),
    .q_o   (sh_q)
  );

  // Window contents as they would be after shifting in the current bit.
  assign win_cand = SW'({s_in, win_q} >> 1);

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    par_err_d  = 1'b0;
    overrun_d  = overrun_q;
    win_en     = 1'b0;
    win_clr    = 1'b0;
    sh_en      = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        if (bit_en) begin
          win_en = 1'b1;
          if (win_cand == SYNC) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          sh_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = PAR;
            cnt_d   = '0;
          end
        end
      end
      PAR: begin
        if (bit_en) begin
          win_clr = 1'b1;
          state_d = HUNT;
          if (even_par(PAR_MAX_W'(sh_q)) ^ s_in) begin
            par_err_d = 1'b1;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
          end else begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    locked_d = (state_d != HUNT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      par_err_q  <= par_err_d;
      overrun_q  <= overrun_d;
      locked_q   <= locked_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign par_err  = par_err_q;
  assign overrun  = overrun_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser with hand-computed expected values.
module tb_serial_frame_deser;

  logic       clk;
  logic       reset;
  logic       bit_en;
  logic       s_in;
  logic       rx_ready;
  logic       clr_ovr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       par_err;
  logic       overrun;
  logic       locked;

  int total;
  int bad;

  serial_frame_deser #(.DW(8), .SW(8), .SYNC(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_en   (bit_en),
    .s_in     (s_in),
    .rx_ready (rx_ready),
    .clr_ovr  (clr_ovr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .par_err  (par_err),
    .overrun  (overrun),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle cycles with bit_en low and random junk on s_in.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      s_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    s_in = 1'b0;
  endtask

  // One serial bit, sampled on the next rising edge.
  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    s_in   = b;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    s_in   = 1'b0;
  endtask

  // Eight bits LSB first, with `gap` idle cycles before each bit.
  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (gap > 0) idle(gap);
      send_bit(v[i]);
    end
  endtask

  // Sync plus data word; the caller sends the parity bit.
  task automatic send_head(input logic [7:0] d, input int gap);
    send_byte(8'hA5, gap);
    send_byte(d, gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bit_en   = 1'b0;
    s_in     = 1'b0;
    rx_ready = 1'b1;
    clr_ovr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_perr", 32'(par_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_lock", 32'(locked), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: good frame 3C, consumer ready.
    send_byte(8'hA5, 0);
    chk("t1_lock_after_sync", 32'(locked), 32'h1);
    send_byte(8'h3C, 0);
    chk("t1_lock_in_par", 32'(locked), 32'h1);
    chk("t1_valid_before_par", 32'(rx_valid), 32'h0);
    send_bit(1'b0);
    chk("t1_valid", 32'(rx_valid), 32'h1);
    chk("t1_data", 32'(rx_data), 32'h3C);
    chk("t1_unlock", 32'(locked), 32'h0);
    chk("t1_perr", 32'(par_err), 32'h0);
    @(posedge clk);
    #1;
    chk("t1_valid_drop", 32'(rx_valid), 32'h0);

    // Test 2: same frame, bad parity.
    send_head(8'h3C, 0);
    send_bit(1'b1);
    chk("t2_perr", 32'(par_err), 32'h1);
    chk("t2_valid", 32'(rx_valid), 32'h0);
    chk("t2_unlock", 32'(locked), 32'h0);
    chk("t2_ovr", 32'(overrun), 32'h0);
    @(posedge clk);
    #1;
    chk("t2_perr_pulse", 32'(par_err), 32'h0);

    // Test 3: consumer stalled, two good words.
    rx_ready = 1'b0;
    send_head(8'h11, 0);
    send_bit(1'b0);
    chk("t3_valid1", 32'(rx_valid), 32'h1);
    chk("t3_data1", 32'(rx_data), 32'h11);
    chk("t3_ovr_clear", 32'(overrun), 32'h0);
    send_head(8'h22, 0);
    send_bit(1'b0);
    chk("t3_data_held", 32'(rx_data), 32'h11);
    chk("t3_valid_held", 32'(rx_valid), 32'h1);
    chk("t3_ovr_set", 32'(overrun), 32'h1);
    idle(3);
    chk("t3_ovr_sticky", 32'(overrun), 32'h1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    chk("t3_ovr_cleared", 32'(overrun), 32'h0);
    chk("t3_valid_kept", 32'(rx_valid), 32'h1);

    // Test 4: consume in the same cycle the next word loads.
    send_head(8'h22, 0);
    rx_ready = 1'b1;
    send_bit(1'b0);
    rx_ready = 1'b0;
    chk("t4_data", 32'(rx_data), 32'h22);
    chk("t4_valid", 32'(rx_valid), 32'h1);
    chk("t4_ovr", 32'(overrun), 32'h0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_consumed", 32'(rx_valid), 32'h0);

    // Test 5: frame 1 with five idle cycles before every bit.
    send_head(8'h3C, 5);
    idle(5);
    chk("t5_valid_before_par", 32'(rx_valid), 32'h0);
    chk("t5_lock_in_par", 32'(locked), 32'h1);
    send_bit(1'b0);
    chk("t5_valid", 32'(rx_valid), 32'h1);
    chk("t5_data", 32'(rx_data), 32'h3C);
    @(posedge clk);
    #1;
    chk("t5_valid_drop", 32'(rx_valid), 32'h0);

    // Test 6: reset mid-frame, then a clean frame F0.
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t6_lock_mid", 32'(locked), 32'h1);
    #2;
    reset = 1'b1;
    #2;
    chk("t6_rst_unlock", 32'(locked), 32'h0);
    chk("t6_rst_valid", 32'(rx_valid), 32'h0);
    chk("t6_rst_data", 32'(rx_data), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_head(8'hF0, 0);
    send_bit(1'b0);
    chk("t6_data", 32'(rx_data), 32'hF0);
    chk("t6_valid", 32'(rx_valid), 32'h1);
    @(posedge clk);
    #1;
    chk("t6_valid_drop", 32'(rx_valid), 32'h0);

    // Sync pattern inside the data word is just data.
    send_head(8'hA5, 0);
    chk("t6_a5_lock_in_par", 32'(locked), 32'h1);
    send_bit(1'b0);
    chk("t6_a5_data", 32'(rx_data), 32'hA5);
    chk("t6_a5_unlock", 32'(locked), 32'h0);
    @(posedge clk);
    #1;
    send_byte(8'h5A, 0);
    chk("t6_5a_no_lock", 32'(locked), 32'h0);
    send_byte(8'hA5, 0);
    chk("t6_resync", 32'(locked), 32'h1);
    send_byte(8'h00, 0);
    send_bit(1'b0);
    chk("t6_zero_data", 32'(rx_data), 32'h00);
    chk("t6_zero_valid", 32'(rx_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
